serial_source_arbiter: RTL and testbench
========================================

# serial_source_arbiter

Round-robin arbiter that shares the single serial deserializer (and the byte queue behind it) between `NUM_REQ` serial bit sources. A requester is granted for one whole word of `WORD_BITS` bits. Its `bit_in`/`bit_valid` are forwarded as `data_in`/`write_in` to the deserializer, so words from different sources never interleave. The block withholds new grants while the queue is full, and flushes the deserializer when a granted source stalls or drops its request mid-word.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `WORD_BITS`, default 8: bits per word; must match the deserializer width.
- `TIMEOUT_CYCLES`, default 16: maximum cycles allowed between accepted bits while granted.
- `clk`  in  1  system clock. This is the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  NUM_REQ  per-source request; held high until the word completes.
- `bit_in`  in  NUM_REQ  per-source serial data bit.
- `bit_valid`  in  NUM_REQ  per-source bit strobe; one bit per high cycle.
- `queue_full`  in  1  byte queue full; sampled only in IDLE.
- `gnt`  out  NUM_REQ  one-hot grant (registered).
- `data_out`  out  1  to deserializer `data_in`.
- `write_out`  out  1  to deserializer `write_in`.
- `flush_out`  out  1  one-cycle active-high pulse to deserializer reset.
- `abort`  out  1  one-cycle pulse when a word is abandoned.
- `abort_id`  out  $clog2(NUM_REQ)  index of the aborted source; valid while `abort` is high.

## Operation
- FSM states: IDLE, GRANT, FLUSH.
- **IDLE**
  - If any `req` is high and `queue_full` is low, pick the first requester at or after the round-robin pointer `rr_ptr`.
  - Set that requester's `gnt` bit, clear `bit_cnt` and `to_cnt`, and go to GRANT.
  - Otherwise stay in IDLE with `gnt` all zero.
- **GRANT**
  - A bit is *accepted* when `bit_valid` of the granted source is high. On each accepted bit, increment `bit_cnt` and clear `to_cnt`.
  - `bit_valid` from non-granted sources is ignored and never forwarded.
  - When the accepted bit is bit number `WORD_BITS`: go to IDLE, clear `gnt`, set `rr_ptr` = (winner+1) mod `NUM_REQ`.
  - If no bit is accepted in a cycle, increment `to_cnt`. When `to_cnt` reaches `TIMEOUT_CYCLES`, go to FLUSH.
  - If the granted `req` is low while `bit_cnt` is below `WORD_BITS`, go to FLUSH immediately. Any bit accepted in that same cycle is discarded.
- **FLUSH** (one cycle)
  - `flush_out` = 1, `abort` = 1, `abort_id` = winner, `gnt` = 0.
  - Set `rr_ptr` = (winner+1) mod `NUM_REQ`, then go to IDLE.
- `queue_full` rising during GRANT is ignored; the word completes.
- Width rules:
  - `bit_cnt` is $clog2(WORD_BITS+1) bits.
  - `to_cnt` is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
  - `rr_ptr` wraps from `NUM_REQ`-1 to 0.

## Timing
- Reset values (`rst_n` low at a clock edge): state IDLE, `gnt`=0, `data_out`=0, `write_out`=0, `flush_out`=0, `abort`=0, `abort_id`=0, `rr_ptr`=0, counters 0.
- Reset mid-word drops the grant at once and does not pulse `flush_out`. The deserializer has its own reset.
- Grant latency: a `req` sampled high in IDLE gives `gnt` high the next cycle. After a word completes there is at least one IDLE cycle before the next grant.
- Forwarding: `write_out`/`data_out` are registered copies of the accepted bit, one cycle after acceptance, one pulse per accepted bit.
- A bit presented in the same cycle `gnt` first goes high is accepted.
- After the last bit is accepted, `gnt` is low the next cycle. That is the same cycle as the last `write_out`.
- Timeout abort: `flush_out` is high exactly one cycle, `TIMEOUT_CYCLES`+1 cycles after the last accepted bit (or after grant entry if no bit was accepted).
- Request-drop abort: `flush_out` is high the cycle after `req` is sampled low.

## Structure
- Package `serial_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE/GRANT/FLUSH);
  - the default constants `WORD_BITS_DEF`=8 and `TIMEOUT_DEF`=16.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `req` and `rr_ptr` and outputs `valid` and `idx`. It is reused by future queue-side schedulers.
- The top-level `top` instantiates this block ahead of the deserializer. `flush_out` is OR-ed into `deserializer_rst`.

## Test plan
- **Basic transfer.** Reset, then hold `req`[0] high. Source 0 sends 8 bits 1,0,1,1,0,0,1,0, each strobed one cycle on / one cycle off.
  - Exactly 8 `write_out` pulses with the same bit order.
  - `gnt`[0] drops after the 8th bit.
  - The queue receives 0xB2 or 0x4D, depending on deserializer bit order, which the bench checks.
- **Round robin.** Hold `req`=2'b11 continuously with both sources streaming.
  - Grants go 0,1,0,1 with one IDLE cycle between them.
  - Four complete words, never interleaved.
- **Backpressure.** Hold `queue_full`=1 with `req`[1] high for 10 cycles.
  - `gnt` stays 0.
  - Dropping `queue_full` gives `gnt`[1]=1 the next cycle.
  - Raising `queue_full` mid-word lets the word still complete.
- **Timeout.** Grant source 1, which sends 3 bits then goes silent.
  - `flush_out` and `abort` pulse once, 17 cycles after the 3rd bit, with `abort_id`=1.
  - The next grant goes to source 0 if it is requesting.
- **Request drop.** Source 0 drops `req` after 5 bits.
  - `flush_out` pulses the next cycle.
  - Any bit strobed in the drop cycle is not forwarded.
- **Reset mid-word.** Assert `rst_n` low after 4 bits.
  - All outputs are at reset values on the next cycle.
  - `rr_ptr`=0, so source 0 wins a tie afterwards.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// Shared types and default constants for the serial source arbiter and
// the queue-side schedulers built around it.
package serial_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  localparam int WORD_BITS_DEF = 8;
  localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/serial_source_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at
// or after rr_ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    logic [IW-1:0] j_idx;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    j_idx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (!valid && req[j_idx]) begin
        valid = 1'b1;
        idx   = j_idx;
      end
    end
  end

endmodule

// File: rtl/serial_source_arbiter.sv
// Round-robin arbiter granting one serial source a whole word at a time onto
// the shared deserializer, flushing it when a granted source stalls or quits.
module serial_source_arbiter
  import serial_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int WORD_BITS      = WORD_BITS_DEF,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEF,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_in,
  input  logic [NUM_REQ-1:0] bit_valid,
  input  logic               queue_full,
  output logic [NUM_REQ-1:0] gnt,
  output logic               data_out,
  output logic               write_out,
  output logic               flush_out,
  output logic               abort,
  output logic [IW-1:0]      abort_id
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     winner, winner_nxt, winner_inc;
  logic [IW-1:0]     rr_ptr, rr_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [TW-1:0]     to_cnt, to_cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic              data_nxt, write_nxt, flush_nxt, abort_nxt;
  logic [IW-1:0]     abort_id_nxt;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign winner_inc = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    winner_nxt   = winner;
    rr_nxt       = rr_ptr;
    bit_cnt_nxt  = bit_cnt;
    to_cnt_nxt   = to_cnt;
    gnt_nxt      = gnt;
    data_nxt     = 1'b0;
    write_nxt    = 1'b0;
    flush_nxt    = 1'b0;
    abort_nxt    = 1'b0;
    abort_id_nxt = '0;

    unique case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (pick_valid && !queue_full) begin
          state_nxt         = GRANT;
          winner_nxt        = pick_idx;
          gnt_nxt[pick_idx] = 1'b1;
          bit_cnt_nxt       = '0;
          to_cnt_nxt        = '0;
        end
      end

      GRANT: begin
        if (!req[winner]) begin
          // A bit strobed alongside the request drop is deliberately lost.
          state_nxt    = FLUSH;
          gnt_nxt      = '0;
          flush_nxt    = 1'b1;
          abort_nxt    = 1'b1;
          abort_id_nxt = winner;
        end else if (bit_valid[winner]) begin
          write_nxt   = 1'b1;
          data_nxt    = bit_in[winner];
          bit_cnt_nxt = bit_cnt + BW'(1);
          to_cnt_nxt  = '0;
          if (bit_cnt == BW'(WORD_BITS - 1)) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            rr_nxt    = winner_inc;
          end
        end else begin
          if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt_nxt = to_cnt + TW'(1);
          if (to_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt    = FLUSH;
            gnt_nxt      = '0;
            flush_nxt    = 1'b1;
            abort_nxt    = 1'b1;
            abort_id_nxt = winner;
          end
        end
      end

      FLUSH: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        rr_nxt    = winner_inc;
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      winner    <= '0;
      rr_ptr    <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      gnt       <= '0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
      flush_out <= 1'b0;
      abort     <= 1'b0;
      abort_id  <= '0;
    end else begin
      state     <= state_nxt;
      winner    <= winner_nxt;
      rr_ptr    <= rr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      gnt       <= gnt_nxt;
      data_out  <= data_nxt;
      write_out <= write_nxt;
      flush_out <= flush_nxt;
      abort     <= abort_nxt;
      abort_id  <= abort_id_nxt;
    end
  end

endmodule

// File: tb/tb_serial_source_arbiter.sv
// Scoreboard bench for serial_source_arbiter: expected bits and words are
// queued as stimulus is driven and compared as write_out pulses appear.
module tb_serial_source_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] bit_in;
  logic [1:0] bit_valid;
  logic       queue_full;
  logic [1:0] gnt;
  logic       data_out;
  logic       write_out;
  logic       flush_out;
  logic       abort;
  logic       abort_id;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  logic exp_bits[$];
  logic [7:0] exp_words[$];
  logic [7:0] shreg = '0;
  int   nbits = 0;

  serial_source_arbiter #(
    .NUM_REQ        (2),
    .WORD_BITS      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .queue_full (queue_full),
    .gnt        (gnt),
    .data_out   (data_out),
    .write_out  (write_out),
    .flush_out  (flush_out),
    .abort      (abort),
    .abort_id   (abort_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit on src for one cycle; noise strobes the other source too.
  task automatic put_bit(input int src, input logic b, input logic expect_fwd,
                         input logic noise);
    bit_in         = noise ? {2{~b}} : 2'b00;
    bit_in[src]    = b;
    bit_valid      = noise ? 2'b11 : 2'b00;
    bit_valid[src] = 1'b1;
    if (expect_fwd) exp_bits.push_back(b);
    tick();
    bit_valid = 2'b00;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = 2'b00;
    bit_in     = 2'b00;
    bit_valid  = 2'b00;
    queue_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Deserializer-side model: MSB-first word assembly, cleared by flush/reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
    end else begin
      if (flush_out) nbits = 0;
      if (write_out) begin
        wr_cnt++;
        if (exp_bits.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          check("fwd_bit", 32'(data_out), 32'(exp_bits.pop_front()));
        end
        shreg = {shreg[6:0], data_out};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_words.size() == 0) check("unexpected_word", 32'(shreg), 32'hFFFF);
          else check("word", 32'(shreg), 32'(exp_words.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int w, cyc, wr0;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_write", 32'(write_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_flush", 32'(flush_out), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_abort_id", 32'(abort_id), 32'd0);

    // Basic transfer
    d = 8'b1011_0010;
    exp_words.push_back(8'hB2);
    wr0 = wr_cnt;
    req = 2'b01;
    tick();
    check("basic_gnt_latency", 32'(gnt), 32'b01);
    for (int i = 0; i < 8; i++) begin
      put_bit(0, d[7-i], 1'b1, 1'b0);
      if (i == 7) begin
        req = 2'b00;
        check("basic_gnt_drop", 32'(gnt), 32'b00);
        check("basic_last_write", 32'(write_out), 32'd1);
      end
      tick();
    end
    check("basic_write_count", 32'(wr_cnt - wr0), 32'd8);

    // Round robin with both sources streaming
    do_reset();
    req = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      d = 8'($urandom_range(0, 255));
      exp_words.push_back(d);
      check("rr_gnt", 32'(gnt), 32'(2'b01 << w));
      for (int i = 0; i < 8; i++) begin
        put_bit(w, d[7-i], 1'b1, 1'b1);
        if (i == 7) begin
          check("rr_idle_gap", 32'(gnt), 32'b00);
          if (k == 3) req = 2'b00;
        end
        tick();
      end
    end

    // Backpressure; rr_ptr is back at 0 after source 1 finished
    queue_full = 1'b1;
    req = 2'b10;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_hold", 32'(gnt), 32'b00);
    end
    queue_full = 1'b0;
    tick();
    check("bp_release", 32'(gnt), 32'b10);
    d = 8'h5C;
    exp_words.push_back(d);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) queue_full = 1'b1;
      put_bit(1, d[7-i], 1'b1, 1'b0);
      if (i == 7) begin
        req = 2'b00;
        check("bp_complete", 32'(gnt), 32'b00);
      end
      tick();
    end
    queue_full = 1'b0;

    // Timeout: source 1 sends 3 bits then goes silent
    req = 2'b10;
    tick();
    check("to_gnt", 32'(gnt), 32'b10);
    req = 2'b11;
    put_bit(1, 1'b1, 1'b1, 1'b0);
    tick();
    put_bit(1, 1'b0, 1'b1, 1'b0);
    tick();
    put_bit(1, 1'b1, 1'b1, 1'b0);
    cyc = 1;
    while (!flush_out && cyc < 40) begin
      tick();
      cyc++;
    end
    check("to_delay", 32'(cyc), 32'd17);
    check("to_abort", 32'(abort), 32'd1);
    check("to_abort_id", 32'(abort_id), 32'd1);
    check("to_gnt_off", 32'(gnt), 32'b00);
    tick();
    check("to_flush_once", 32'(flush_out), 32'd0);
    check("to_abort_once", 32'(abort), 32'd0);
    tick();
    check("to_next_gnt", 32'(gnt), 32'b01);
    req = 2'b01;

    // Request drop after 5 bits from source 0
    d = 8'b0110_1001;
    for (int i = 0; i < 5; i++) begin
      put_bit(0, d[7-i], 1'b1, 1'b0);
      tick();
    end
    req = 2'b00;
    put_bit(0, 1'b1, 1'b0, 1'b0);
    check("drop_flush", 32'(flush_out), 32'd1);
    check("drop_abort_id", 32'(abort_id), 32'd0);
    check("drop_no_write", 32'(write_out), 32'd0);
    tick();
    check("drop_flush_once", 32'(flush_out), 32'd0);

    // Reset mid-word: rr_ptr=1 now so source 1 wins first
    req = 2'b11;
    tick();
    check("rm_gnt", 32'(gnt), 32'b10);
    for (int i = 0; i < 4; i++) begin
      put_bit(1, i[0], 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("rm_gnt_reset", 32'(gnt), 32'b00);
    check("rm_write_reset", 32'(write_out), 32'd0);
    check("rm_flush_none", 32'(flush_out), 32'd0);
    check("rm_abort_none", 32'(abort), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rm_tie_src0", 32'(gnt), 32'b01);
    req = 2'b01;
    d = 8'hE7;
    exp_words.push_back(d);
    for (int i = 0; i < 8; i++) begin
      put_bit(0, d[7-i], 1'b1, 1'b0);
      if (i == 7) req = 2'b00;
      tick();
    end
    tick();
    tick();

    check("sb_bits_drained", 32'(exp_bits.size()), 32'd0);
    check("sb_words_drained", 32'(exp_words.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
